// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and constants for the two-requester mux arbiter.
// Included by mux_arbiter and mux_arb_hold_cnt.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_e;

    localparam int unsigned HOLD_CNT_W = 8;

    localparam logic SEL_D0 = 1'b0;
    localparam logic SEL_D1 = 1'b1;

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// mux_arb_hold_cnt: counts granted cycles of the current tenure and flags when
// the holder has used its MAX_HOLD-cycle budget.
module mux_arb_hold_cnt
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enter,
    input  logic granted,
    output logic hit
);

    localparam logic [HOLD_CNT_W-1:0] LIM = HOLD_CNT_W'(MAX_HOLD - 1);

    logic [HOLD_CNT_W-1:0] cnt_q;
    logic [HOLD_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enter) begin
            cnt_d = '0;
        end else if (granted && (cnt_q != LIM)) begin
            cnt_d = cnt_q + HOLD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = granted && (cnt_q == LIM);

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter driving a shared 2:1 data path.
// Define MUX_ARB_TIMEOUT_EN to bound a contended grant to MAX_HOLD cycles.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned DATA_W   = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              s,
    output logic [DATA_W-1:0] b,
    output logic              out_valid
);

    arb_state_e state_q;
    arb_state_e state_d;

    logic              last_q;
    logic              last_d;
    logic              s_q;
    logic              s_d;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] b_d;
    logic              valid_q;
    logic              valid_d;

    logic granted;
    logic enter;
    logic hold_hit;

    assign granted = (state_q != IDLE);
    assign enter   = (state_d != state_q) && (state_d != IDLE);

`ifdef MUX_ARB_TIMEOUT_EN
    mux_arb_hold_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .enter   (enter),
        .granted (granted),
        .hit     (hold_hit)
    );
`else
    // Legal MAX_HOLD is never zero, so the limit can never fire here.
    assign hold_hit = (MAX_HOLD == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = (last_q == SEL_D0) ? G1 : G0;
                end else if (req0) begin
                    state_d = G0;
                end else if (req1) begin
                    state_d = G1;
                end
            end
            G0: begin
                if (!req0) begin
                    state_d = req1 ? G1 : IDLE;
                end else if (hold_hit && req1) begin
                    state_d = G1;
                end
            end
            G1: begin
                if (!req1) begin
                    state_d = req0 ? G0 : IDLE;
                end else if (hold_hit && req0) begin
                    state_d = G0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            G0:      gnt0 = 1'b1;
            G1:      gnt1 = 1'b1;
            default: ;
        endcase
    end

    // Pointer and select move only on grant entry; select holds through IDLE.
    always_comb begin
        last_d = last_q;
        s_d    = s_q;
        if (enter) begin
            last_d = (state_d == G1) ? SEL_D1 : SEL_D0;
            s_d    = (state_d == G1) ? SEL_D1 : SEL_D0;
        end
    end

    always_comb begin
        b_d     = b_q;
        valid_d = 1'b0;
        if (granted) begin
            b_d     = (s_q == SEL_D1) ? d1 : d0;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= SEL_D1;
            s_q     <= SEL_D0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            last_q  <= last_d;
            s_q     <= s_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    assign s         = s_q;
    assign b         = b_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed and randomized checks of mux_arbiter against a
// tenure-level model of the round-robin and hold-limit rules.
module tb_mux_arbiter;

    localparam int DW = 8;
    localparam int MH = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0  = 1'b0;
    logic          req1  = 1'b0;
    logic [DW-1:0] d0    = '0;
    logic [DW-1:0] d1    = '0;
    logic          gnt0;
    logic          gnt1;
    logic          s;
    logic [DW-1:0] b;
    logic          out_valid;

    int n_run  = 0;
    int n_fail = 0;

    // Model: owner (-1 none, 0, 1), last winner, cycles held this tenure.
    int            own;
    int            last;
    int            held;
    logic          m_s;
    logic [DW-1:0] m_b;
    logic          m_v;

    always #5 clk = ~clk;

    mux_arbiter #(
        .DATA_W   (DW),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .d0        (d0),
        .d1        (d1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .s         (s),
        .b         (b),
        .out_valid (out_valid)
    );

    task automatic model_reset();
        own  = -1;
        last = 1;
        held = 0;
        m_s  = 1'b0;
        m_b  = '0;
        m_v  = 1'b0;
    endtask

    task automatic model_step();
        int nxt;
        bit r[2];
        r[0] = req0;
        r[1] = req1;
        if (own >= 0) begin
            m_b = m_s ? d1 : d0;
            m_v = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        nxt = own;
        if (own < 0) begin
            if (r[0] && r[1]) nxt = 1 - last;
            else if (r[0]) nxt = 0;
            else if (r[1]) nxt = 1;
        end else if (!r[own]) begin
            nxt = r[1-own] ? 1 - own : -1;
        end else if (TO_EN && held >= MH && r[1-own]) begin
            nxt = 1 - own;
        end
        if (nxt >= 0 && nxt != own) begin
            last = nxt;
            held = 1;
            m_s  = (nxt == 1);
        end else if (nxt >= 0) begin
            held++;
        end
        own = nxt;
    endtask

    function automatic logic [DW+3:0] exp_vec();
        return {own == 0, own == 1, m_s, m_b, m_v};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        req0  = 1'b0;
        req1  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        n_run++;
        if ({gnt0, gnt1, s, b, out_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset: got %h want 0", {gnt0, gnt1, s, b, out_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req0 = 1'b1;
        d0   = 8'd1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 2) req0 = 1'b0;
            n_run++;
            if ({gnt0, gnt1, s, b, out_valid} !== exp_vec()) begin
                n_fail++;
                $display("FAIL single c%0d: got %h want %h", i, {gnt0, gnt1, s, b, out_valid}, exp_vec());
            end
            n_run++;
            if (i == 1 && {gnt0, s, out_valid} !== 3'b100) begin
                n_fail++;
                $display("FAIL single_grant: got %b want 100", {gnt0, s, out_valid});
            end else if (i == 2 && {b, out_valid} !== {8'd1, 1'b1}) begin
                n_fail++;
                $display("FAIL single_data: got %h/%b want 01/1", b, out_valid);
            end else if (i == 3 && {gnt0, out_valid} !== 2'b01) begin
                n_fail++;
                $display("FAIL single_release: got %b want 01", {gnt0, out_valid});
            end else if (i == 4 && out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_tail: got %b want 0", out_valid);
            end
        end
    endtask

    task automatic test_handover();
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            d0 = DW'($urandom);
            d1 = DW'($urandom);
            tick();
            if (i == 3) req0 = 1'b0;
            if (i == 6) req1 = 1'b0;
            n_run++;
            if ({gnt0, gnt1, s, b, out_valid} !== exp_vec()) begin
                n_fail++;
                $display("FAIL handover c%0d: got %h want %h", i, {gnt0, gnt1, s, b, out_valid}, exp_vec());
            end
            if (i >= 2) begin
                n_run++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL handover_gap c%0d: got out_valid %b want 1", i, out_valid);
                end
            end
        end
        n_run++;
        if (last != 1) begin
            n_fail++;
            $display("FAIL handover_last: got %0d want 1", last);
        end
    endtask

    task automatic test_tie();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req0 = 1'b1;
            req1 = 1'b1;
            d0   = DW'($urandom);
            d1   = DW'($urandom);
            tick();
            req0 = 1'b0;
            req1 = 1'b0;
            n_run++;
            if ({gnt0, gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL tie k%0d: got %b want %b", k, {gnt0, gnt1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            for (int j = 0; j < 2; j++) begin
                tick();
                n_run++;
                if ({gnt0, gnt1, s, b, out_valid} !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL tie_idle k%0d: got %h want %h", k, {gnt0, gnt1, s, b, out_valid}, exp_vec());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req1 = 1'b1;
        d1   = 8'hA5;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_run++;
        if ({gnt0, gnt1, s, b, out_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h want 0", {gnt0, gnt1, s, b, out_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_run++;
        if ({gnt0, gnt1, s} !== 3'b011) begin
            n_fail++;
            $display("FAIL reset_regrant: got %b want 011", {gnt0, gnt1, s});
        end
    endtask

    task automatic test_hold();
        int  cnt;
        bool_t: begin end
        cnt  = 0;
        do_reset();
        req0 = 1'b1;
        tick();
        if (gnt0) cnt++;
        req1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d0 = DW'($urandom);
            d1 = DW'($urandom);
            tick();
            n_run++;
            if ({gnt0, gnt1, s, b, out_valid} !== exp_vec()) begin
                n_fail++;
                $display("FAIL hold c%0d: got %h want %h", i, {gnt0, gnt1, s, b, out_valid}, exp_vec());
            end
            if (gnt1) break;
            if (gnt0) cnt++;
        end
        n_run++;
        if (cnt != (TO_EN ? MH : 13)) begin
            n_fail++;
            $display("FAIL hold_len: got %0d want %0d", cnt, TO_EN ? MH : 13);
        end
    endtask

    task automatic test_alone();
        do_reset();
        req0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d0 = DW'($urandom);
            tick();
            n_run++;
            if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
                n_fail++;
                $display("FAIL alone c%0d: got %b want 10", i, {gnt0, gnt1});
            end
        end
        n_run++;
        if ({gnt0, gnt1, s, b, out_valid} !== exp_vec()) begin
            n_fail++;
            $display("FAIL alone_data: got %h want %h", {gnt0, gnt1, s, b, out_valid}, exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req0 = ~req0;
            if ($urandom_range(0, 3) == 0) req1 = ~req1;
            d0 = DW'($urandom);
            d1 = DW'($urandom);
            tick();
            n_run++;
            if ({gnt0, gnt1, s, b, out_valid} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random c%0d: got %h want %h", i, {gnt0, gnt1, s, b, out_valid}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_handover();
        test_tie();
        test_reset_mid();
        test_hold();
        test_alone();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that shares one 2:1 select path between two sources. Drives the select line and one-hot grants, and registers the selected data with a valid flag. Sits in front of the shared output channel. Each requester holds its grant for a multi-cycle transfer, and an optional hold limit bounds how long one side can starve the other.

## Interface
- DATA_W, 1, width of each data input and of the muxed output
- MAX_HOLD, 8, maximum consecutive granted cycles while the other side waits (used only with MUX_ARB_TIMEOUT_EN; legal range 2..255)
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req0  input  1  requester 0 wants the channel; held high for the whole transfer
- req1  input  1  requester 1 wants the channel; held high for the whole transfer
- d0  input  DATA_W  requester 0 data
- d1  input  DATA_W  requester 1 data
- gnt0  output  1  requester 0 owns the channel (registered)
- gnt1  output  1  requester 1 owns the channel (registered)
- s  output  1  mux select: 0 = d0, 1 = d1 (registered)
- b  output  DATA_W  registered muxed data
- out_valid  output  1  b carries granted data this cycle

## Operation
- States:
  - IDLE: no grant.
  - G0: gnt0=1, s=0.
  - G1: gnt1=1, s=1.
- Grants are one-hot or all-zero; never both.
- Round-robin pointer `last` names the most recently granted side. It updates on every entry to G0 or G1.
- IDLE:
  - only req0 -> G0
  - only req1 -> G1
  - both -> the side != last
  - none -> stay
- G0 (G1 symmetric):
  - req0 high -> stay, unless the hold limit fires (see Configuration).
  - req0 low with req1 high -> G1 directly, no idle bubble.
  - req0 low with req1 low -> IDLE.
- s changes only on entry to G0/G1; it keeps its last value in IDLE.
- Data register each cycle:
  - if gnt0|gnt1: b <= s ? d1 : d0, out_valid <= 1.
  - otherwise: b holds its value, out_valid <= 0.
- Reset values: state IDLE, last=1 (requester 0 wins the first tie), gnt0=0, gnt1=0, s=0, b=0, out_valid=0, hold count=0.
- Asserting rst_n low mid-transfer forces all of the above immediately, without waiting for a clock edge. The first grant after reset release follows the IDLE rules.

## Timing
- Request to grant: a request sampled high at edge k gives gnt/s valid after edge k.
- Grant to data: data presented while gnt is high is sampled at edge k+1. b/out_valid are valid after edge k+1, so there is 1 cycle of data latency behind the grant.
- Request to first data: 2 cycles from the request edge to the first out_valid.
- Release: req dropped before edge m -> gnt low after edge m; the last out_valid appears after edge m.
- Handover: on a direct handover (G0->G1), out_valid stays high continuously and b switches source one cycle after s.
- Requesters must present valid data on every cycle their gnt is high.

## Configuration
- MUX_ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on each grant entry and increments each granted cycle, saturating at MAX_HOLD-1.
  - When the counter equals MAX_HOLD-1 and the other side is requesting, the grant switches at the next edge even though the holder still requests.
  - The preempted holder simply waits with req high and is regranted later under round-robin.
  - If the other side is not requesting, the holder keeps the grant and the counter stays saturated.
- Not defined: no counter logic; the grant is held until the holder drops req (unbounded).

## Structure
- Shared package mux_arb_pkg:
  - state enum (IDLE, G0, G1)
  - HOLD_CNT_W = 8
  - encoding constants SEL_D0 = 0, SEL_D1 = 1
- One sub-module: mux_arb_hold_cnt, containing the counter, saturation and the limit-reached flag. It is instantiated only under MUX_ARB_TIMEOUT_EN.
- The FSM and data register stay in the top.

## Test plan
- Reset, then req0=1 only, d0=1: gnt0=1, s=0 after edge 1; b=1, out_valid=1 after edge 2; drop req0 -> gnt0=0 next edge, out_valid=0 one edge later.
- req0=req1=1 from the same edge after reset: G0 first. req0 drops after 3 cycles -> G1 with no gap in out_valid; b switches to d1 one cycle after s=1.
- Both request in IDLE with last=0: G1 chosen; repeated tie sequences alternate G0/G1/G0.
- Assert rst_n low mid-G1 between edges: gnt1, s, b, out_valid go to 0 immediately. After release with only req1 high, grant returns to G1.
- With MUX_ARB_TIMEOUT_EN, MAX_HOLD=4, req0 constantly high and req1 raised at cycle 1 of G0: switch to G1 after exactly 4 granted cycles. Without the macro, G0 holds indefinitely.
- Timeout, alone requester: MUX_ARB_TIMEOUT_EN, req0 alone for 20 cycles -> gnt0 stays high throughout, with no spurious switch.
